// File: rtl/id_ex_stage_pkg.sv
// Shared types and encodings for the decode-to-execute stage.
// ALU op encodings match what the downstream ALU expects on its 4-bit select.
package id_ex_stage_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_INV = 4'b1111
    } alu_op_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic illegal;
    } ctrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of upstream (decode) and downstream (execute) signals of the stage.
// master = the surrounding pipeline, slave = the id_ex_stage itself.
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32
);
    // Handshake: a transfer happens on a rising clk edge where valid && ready.
    // Valid never depends on ready; the producer holds its payload stable until it transfers.
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    alu_op_t         aluop;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc_out;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            illegal;

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, data1, data2, aluop, store_data, pc_out, rd,
               reg_write, mem_read, mem_write, branch, illegal
    );

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, data1, data2, aluop, store_data, pc_out, rd,
               reg_write, mem_read, mem_write, branch, illegal
    );

endinterface

// File: rtl/id_ex_stage_instr_decode.sv
// Purely combinational RV32I subset decoder: selects ALU operands, op and control bits.
// Anything outside the supported subset decodes to ALU_INV with every side effect cleared.
module instr_decode
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic [XLEN-1:0] o_data1,
    output logic [XLEN-1:0] o_data2,
    output alu_op_t         o_aluop,
    output logic [4:0]      o_rd,
    output ctrl_t           o_ctrl
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_u;
    logic            w_legal;
    logic            w_writes_rd;
    alu_op_t         w_op;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign o_rd     = i_instr[11:7];

    assign w_imm_i = XLEN'($signed(i_instr[31:20]));
    assign w_imm_s = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
    assign w_imm_u = XLEN'($signed({i_instr[31:12], 12'b0}));

    always_comb begin
        w_legal          = 1'b0;
        w_writes_rd      = 1'b0;
        w_op             = ALU_INV;
        o_data1          = i_rs1_data;
        o_data2          = i_rs2_data;
        o_ctrl.mem_read  = 1'b0;
        o_ctrl.mem_write = 1'b0;
        o_ctrl.branch    = 1'b0;

        case (w_opcode)
            OP_R: begin
                w_writes_rd = 1'b1;
                w_legal     = 1'b1;
                if (w_funct3 == F3_ADD_SUB && w_funct7 == F7_ZERO)      w_op = ALU_ADD;
                else if (w_funct3 == F3_ADD_SUB && w_funct7 == F7_SUB)  w_op = ALU_SUB;
                else if (w_funct3 == F3_AND && w_funct7 == F7_ZERO)     w_op = ALU_AND;
                else if (w_funct3 == F3_OR && w_funct7 == F7_ZERO)      w_op = ALU_OR;
                else                                                    w_legal = 1'b0;
            end
            OP_IMM: begin
                w_writes_rd = 1'b1;
                w_legal     = 1'b1;
                o_data2     = w_imm_i;
                if (w_funct3 == F3_ADD_SUB)  w_op = ALU_ADD;
                else if (w_funct3 == F3_AND) w_op = ALU_AND;
                else if (w_funct3 == F3_OR)  w_op = ALU_OR;
                else                         w_legal = 1'b0;
            end
            OP_LOAD: begin
                if (w_funct3 == F3_LW) begin
                    w_legal         = 1'b1;
                    w_writes_rd     = 1'b1;
                    w_op            = ALU_ADD;
                    o_data2         = w_imm_i;
                    o_ctrl.mem_read = 1'b1;
                end
            end
            OP_STORE: begin
                if (w_funct3 == F3_SW) begin
                    w_legal          = 1'b1;
                    w_op             = ALU_ADD;
                    o_data2          = w_imm_s;
                    o_ctrl.mem_write = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (w_funct3 == F3_BEQ || w_funct3 == F3_BNE) begin
                    w_legal       = 1'b1;
                    w_op          = ALU_SUB;
                    o_ctrl.branch = 1'b1;
                end
            end
            OP_LUI: begin
                w_legal     = 1'b1;
                w_writes_rd = 1'b1;
                w_op        = ALU_ADD;
                o_data1     = '0;
                o_data2     = w_imm_u;
            end
            OP_AUIPC: begin
                w_legal     = 1'b1;
                w_writes_rd = 1'b1;
                w_op        = ALU_ADD;
                o_data1     = i_pc;
                o_data2     = w_imm_u;
            end
            default: w_legal = 1'b0;
        endcase

        // Illegal encodings must never leave a side effect behind.
        if (!w_legal) begin
            w_op             = ALU_INV;
            w_writes_rd      = 1'b0;
            o_ctrl.mem_read  = 1'b0;
            o_ctrl.mem_write = 1'b0;
            o_ctrl.branch    = 1'b0;
        end
    end

    assign o_aluop          = w_op;
    assign o_ctrl.illegal   = !w_legal;
    assign o_ctrl.reg_write = w_writes_rd && (i_instr[11:7] != 5'd0);

endmodule

// File: rtl/id_ex_stage.sv
// Single-entry decode-to-execute pipeline register with valid/ready handshake and flush.
// in_ready looks only at the output side, so a full entry can be replaced in the cycle it drains.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    id_ex_stage_if.slave   bus
);

    logic [XLEN-1:0] w_data1;
    logic [XLEN-1:0] w_data2;
    alu_op_t         w_aluop;
    logic [4:0]      w_rd;
    ctrl_t           w_ctrl;
    logic            w_accept;

    logic            r_out_valid;
    logic [XLEN-1:0] r_data1;
    logic [XLEN-1:0] r_data2;
    alu_op_t         r_aluop;
    logic [XLEN-1:0] r_store_data;
    logic [XLEN-1:0] r_pc_out;
    logic [4:0]      r_rd;
    ctrl_t           r_ctrl;

    instr_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .i_instr    (bus.instr),
        .i_pc       (bus.pc),
        .i_rs1_data (bus.rs1_data),
        .i_rs2_data (bus.rs2_data),
        .o_data1    (w_data1),
        .o_data2    (w_data2),
        .o_aluop    (w_aluop),
        .o_rd       (w_rd),
        .o_ctrl     (w_ctrl)
    );

    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Flush wins over accept and hold; payload registers only move on a kept accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_data1      <= '0;
            r_data2      <= '0;
            r_aluop      <= ALU_ADD;
            r_store_data <= '0;
            r_pc_out     <= RESET_PC;
            r_rd         <= '0;
            r_ctrl       <= '0;
        end else if (bus.flush) begin
            r_out_valid  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_data1      <= w_data1;
            r_data2      <= w_data2;
            r_aluop      <= w_aluop;
            r_store_data <= bus.rs2_data;
            r_pc_out     <= bus.pc;
            r_rd         <= w_rd;
            r_ctrl       <= w_ctrl;
        end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.data1      = r_data1;
    assign bus.data2      = r_data2;
    assign bus.aluop      = r_aluop;
    assign bus.store_data = r_store_data;
    assign bus.pc_out     = r_pc_out;
    assign bus.rd         = r_rd;
    assign bus.reg_write  = r_ctrl.reg_write;
    assign bus.mem_read   = r_ctrl.mem_read;
    assign bus.mem_write  = r_ctrl.mem_write;
    assign bus.branch     = r_ctrl.branch;
    assign bus.illegal    = r_ctrl.illegal;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage that sits directly upstream of the ALU.
- Accepts one instruction word per handshake, together with its PC and register-file read data.
- Decodes the ALU operation, operand sources and control bits, then registers the result into data1/data2/aluop plus side-band control for the execute stage.
- Single-entry valid/ready buffer with flush; throughput is 1 instruction per cycle.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, value of pc_out after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  RV32I instruction word.
- pc  in  XLEN  instruction PC.
- rs1_data  in  XLEN  register-file read port 1.
- rs2_data  in  XLEN  register-file read port 2.
- flush  in  1  kill the held entry and any entry being accepted.
- out_valid  out  1  outputs hold a valid decoded instruction.
- out_ready  in  1  execute stage consumes this cycle.
- data1  out  XLEN  ALU operand A.
- data2  out  XLEN  ALU operand B.
- aluop  out  4  alu_op_t.
- store_data  out  XLEN  rs2_data, for stores.
- pc_out  out  XLEN  registered PC.
- rd  out  5  destination register.
- reg_write, mem_read, mem_write, branch, illegal  out  1 each  control bits.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0; all data outputs 0; pc_out=RESET_PC; aluop=ALU_ADD; all control bits 0.
  - Reset asserted mid-stall drops the held entry. There is no recovery or replay.
- in_ready = !out_valid || out_ready (combinational). Accept fires when in_valid && in_ready.
- Latency: the decode of an accepted instruction appears on the outputs the next cycle with out_valid=1.
- Hold: when out_valid && !out_ready, every output stays stable and in_ready=0.
- Consume without new accept: out_valid→0; data outputs hold their last values (don't-care).
- Simultaneous consume and accept: the new entry replaces the old one; no bubble.
- Flush: next cycle out_valid=0. Any accept in the same cycle is discarded. Flush has priority over accept and hold.
- Decode, keyed on opcode (funct3/funct7 as listed):
  - 0110011 R-type: data1=rs1, data2=rs2.
    - f3=000, f7=0000000 → ALU_ADD.
    - f3=000, f7=0100000 → ALU_SUB.
    - f3=111, f7=0 → ALU_AND.
    - f3=110, f7=0 → ALU_OR.
    - All others illegal.
  - 0010011 I-ALU: data2=sign-extended imm[31:20].
    - f3=000 → ADD; 111 → AND; 110 → OR.
    - All others illegal.
  - 0000011 load, f3=010: ADD, data2=imm_i, mem_read=1.
  - 0100011 store, f3=010: ADD, data2=imm_s, mem_write=1, reg_write=0.
  - 1100011 branch, f3=000 or 001: SUB, data2=rs2, branch=1, reg_write=0.
  - 0110111 LUI: data1=0, data2={instr[31:12],12'b0}, ADD.
  - 0010111 AUIPC: data1=pc, data2=imm_u, ADD.
  - Any other opcode/funct combination: illegal=1, aluop=ALU_INV, reg_write=mem_read=mem_write=branch=0.
- reg_write=1 only for R, I-ALU, load, LUI and AUIPC, and only when rd≠0.
- store_data=rs2_data for every instruction.

Decomposition:
- Shared package holds:
  - alu_op_t (4-bit): ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_INV=4'b1111.
  - Opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC).
  - funct3/funct7 constants.
- One combinational sub-module, instr_decode: instr, pc, rs1_data and rs2_data in; unregistered decode bundle out.
- id_ex_stage owns the handshake and the registers.

Test Plan:
- add x3,x1,x2 (32'h002081B3), rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, data1=5, data2=7, aluop=4'b0010, rd=3, reg_write=1.
- sub x3,x1,x2 (32'h402081B3) followed back-to-back by addi x5,x0,-1 (32'hFFF00293, rs1=0) → cycle 1: aluop=4'b0110. Cycle 2: aluop=4'b0010, data1=0, data2=32'hFFFFFFFF, rd=5. in_ready stays 1 throughout.
- sw x2,8(x1) (32'h0020A423), rs1=32'h100, rs2=32'hDEADBEEF → data1=32'h100, data2=8, store_data=32'hDEADBEEF, mem_write=1, reg_write=0.
- Stall: valid add held with out_ready=0 for 3 cycles while in_valid=1 → in_ready=0 and outputs unchanged. Raise out_ready → next instruction appears the following cycle.
- Flush: flush=1 while an entry is held and in_valid=1 → next cycle out_valid=0 and the incoming instruction never appears. rst_n pulsed low mid-stall → out_valid=0 immediately, without waiting for a clock edge.
- Illegal 32'hFFFFFFFF → aluop=4'b1111, illegal=1, reg_write=0, mem_write=0. ANDI with rd=0 (32'h0FF0F013) → aluop=4'b0000, reg_write=0.
